ex_divider: RTL and testbench

Multi-cycle radix-2 integer divider for the EX stage. It executes DIV and DIVU, writes quotient to LO and remainder to HI, and raises `EX_ALU_Stall` toward the hazard controller. The hazard controller freezes EX and everything behind it until the result is ready. The block then holds its result until the dividing instruction actually leaves EX, which may happen later if a downstream stall is active.

---
 rtl/ex_divider.sv | 135 +++++++++++++
 tb/tb_ex_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ex_divider.sv
// ex_divider: multi-cycle radix-2 restoring divider for the EX stage.
// Executes DIV/DIVU over 32 iterations, writes quotient to LO and remainder
// to HI, and holds EX via EX_ALU_Stall until the result is ready.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no divide in flight; a new op starts here and is stalled
// BUSY  | one restoring step per cycle, cnt counts 0..31
// DONE  | HI/LO valid, waiting for the instruction to leave EX
module ex_divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        Op_Div,
    input  logic        Op_Divu,
    input  logic        Flush,
    input  logic        EX_Stall,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic        EX_ALU_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        HiLo_Write
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        q_neg;
    logic        r_neg;

    logic        op_any;
    logic        start;
    logic        last_step;
    logic        div_zero;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic        q_neg_in;
    logic        r_neg_in;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign op_any    = Op_Div | Op_Divu;
    assign start     = (state == IDLE) & op_any & ~Flush;
    assign last_step = (state == BUSY) & (cnt == 5'd31);

    // Divide by zero keeps the raw dividend and skips sign handling, so the
    // unsigned iteration naturally yields LO = all ones and HI = Dividend.
    assign div_zero = (Divisor == 32'd0);
    assign q_neg_in = Op_Div & ~div_zero & (Dividend[31] ^ Divisor[31]);
    assign r_neg_in = Op_Div & ~div_zero & Dividend[31];
    assign dvd_mag  = (Op_Div & ~div_zero & Dividend[31]) ? (32'd0 - Dividend) : Dividend;
    assign dvs_mag  = (Op_Div & Divisor[31]) ? (32'd0 - Divisor) : Divisor;

    // One restoring step: quo doubles as the dividend shift register, its MSB
    // feeds the partial remainder while quotient bits enter at the LSB.
    assign shifted  = {rem, quo[31]};
    assign diff     = shifted - {1'b0, dvs};
    assign rem_step = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_step = {quo[30:0], ~diff[32]};
    assign quo_fix  = q_neg ? (32'd0 - quo_step) : quo_step;
    assign rem_fix  = r_neg ? (32'd0 - rem_step) : rem_step;

    // Stall never depends on EX_Stall, which keeps the hazard path loop-free.
    assign EX_ALU_Stall = reset_n & ~Flush & (((state == IDLE) & op_any) | (state == BUSY));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a flush kills the instruction from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = BUSY;
            BUSY: if (cnt == 5'd31) state_nxt = DONE;
            DONE: if (!EX_Stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Flush) begin
            state_nxt = IDLE;
        end
    end

    // Operand capture, iteration datapath and HI/LO result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 5'd0;
            quo        <= 32'd0;
            rem        <= 32'd0;
            dvs        <= 32'd0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            HI         <= 32'd0;
            LO         <= 32'd0;
            HiLo_Write <= 1'b0;
        end else begin
            HiLo_Write <= last_step & ~Flush;
            if (start) begin
                cnt   <= 5'd0;
                quo   <= dvd_mag;
                rem   <= 32'd0;
                dvs   <= dvs_mag;
                q_neg <= q_neg_in;
                r_neg <= r_neg_in;
            end else if ((state == BUSY) && !Flush) begin
                cnt <= cnt + 5'd1;
                quo <= quo_step;
                rem <= rem_step;
                if (cnt == 5'd31) begin
                    LO <= quo_fix;
                    HI <= rem_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_divider.sv
// Directed bench for ex_divider: hand-computed quotient/remainder vectors,
// stall length, HiLo_Write pulse count, flush and mid-divide reset.
module tb_ex_divider;

    logic        clock;
    logic        reset_n;
    logic        Op_Div;
    logic        Op_Divu;
    logic        Flush;
    logic        EX_Stall;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        EX_ALU_Stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        HiLo_Write;

    int checks;
    int errors;

    ex_divider dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .Op_Div       (Op_Div),
        .Op_Divu      (Op_Divu),
        .Flush        (Flush),
        .EX_Stall     (EX_Stall),
        .Dividend     (Dividend),
        .Divisor      (Divisor),
        .EX_ALU_Stall (EX_ALU_Stall),
        .HI           (HI),
        .LO           (LO),
        .HiLo_Write   (HiLo_Write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Caller is just past a rising edge. Issues the op in this cycle, runs to
    // DONE, holds DONE for 'hold' extra cycles, and returns just past the edge
    // on which the instruction leaves EX (ops dropped there).
    task automatic do_div(input string tag, input logic sgn, input logic usgn,
                          input logic [31:0] a, input logic [31:0] b, input int hold,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   stall_cycles;
        int   pulses;
        int   done_stall;
        logic reached;
        stall_cycles = 0;
        pulses       = 0;
        done_stall   = 0;
        reached      = 1'b0;
        Op_Div   = sgn;
        Op_Divu  = usgn;
        Dividend = a;
        Divisor  = b;
        EX_Stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (HiLo_Write) pulses++;
            if (!EX_ALU_Stall) begin
                reached = 1'b1;
                break;
            end
            stall_cycles++;
            @(posedge clock);
            #1;
            Dividend = $urandom;
            Divisor  = $urandom;
        end
        check_val({tag, " done_reached"}, {31'd0, reached}, 32'd1);
        check_val({tag, " stall_cycles"}, stall_cycles, 32'd33);
        check_val({tag, " first_done_pulse"}, {31'd0, HiLo_Write}, 32'd1);
        check_val({tag, " LO"}, LO, exp_lo);
        check_val({tag, " HI"}, HI, exp_hi);
        EX_Stall = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            if (i == hold - 1) EX_Stall = 1'b0;
            @(negedge clock);
            if (HiLo_Write) pulses++;
            if (EX_ALU_Stall) done_stall++;
        end
        if (hold > 0) begin
            check_val({tag, " done_hold_stall"}, done_stall, 32'd0);
            check_val({tag, " LO_held"}, LO, exp_lo);
        end
        check_val({tag, " pulses"}, pulses, 32'd1);
        @(posedge clock);
        #1;
        Op_Div  = 1'b0;
        Op_Divu = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        Op_Div   = 1'b0;
        Op_Divu  = 1'b1;
        Flush    = 1'b0;
        EX_Stall = 1'b0;
        Dividend = 32'd100;
        Divisor  = 32'd7;

        repeat (2) @(posedge clock);
        #1;
        check_val("reset stall", {31'd0, EX_ALU_Stall}, 32'd0);
        check_val("reset HI", HI, 32'd0);
        check_val("reset LO", LO, 32'd0);
        check_val("reset hilo_write", {31'd0, HiLo_Write}, 32'd0);
        Op_Divu = 1'b0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        do_div("divu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 0, 32'd14, 32'd2);
        @(posedge clock);
        #1;
        // Both ops high: signed wins.
        do_div("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("div_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 32'd1);
        do_div("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0);
        do_div("divu_5_0", 1'b0, 1'b1, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5);
        do_div("div_m5_0", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Flush at T10 of DIVU 1000/3.
        begin
            int flush_pulses;
            flush_pulses = 0;
            Op_Divu  = 1'b1;
            Dividend = 32'd1000;
            Divisor  = 32'd3;
            repeat (10) begin
                @(posedge clock);
                if (HiLo_Write) flush_pulses++;
            end
            #1;
            Flush = 1'b1;
            @(negedge clock);
            check_val("flush T10 stall", {31'd0, EX_ALU_Stall}, 32'd0);
            @(posedge clock);
            #1;
            Flush   = 1'b0;
            Op_Divu = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (HiLo_Write) flush_pulses++;
                if (i == 0) check_val("flush T11 stall", {31'd0, EX_ALU_Stall}, 32'd0);
            end
            check_val("flush HI kept", HI, 32'hFFFF_FFFB);
            check_val("flush LO kept", LO, 32'hFFFF_FFFF);
            check_val("flush no hilo_write", flush_pulses, 32'd0);
            @(posedge clock);
            #1;
        end

        do_div("divu_9_2_hold", 1'b0, 1'b1, 32'd9, 32'd2, 3, 32'd4, 32'd1);
        do_div("divu_20_6", 1'b0, 1'b1, 32'd20, 32'd6, 0, 32'd3, 32'd2);

        // Reset at T15 of a divide.
        Op_Divu  = 1'b1;
        Dividend = 32'd12345;
        Divisor  = 32'd11;
        repeat (15) @(posedge clock);
        #2;
        check_val("pre_reset stall", {31'd0, EX_ALU_Stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("mid_reset stall", {31'd0, EX_ALU_Stall}, 32'd0);
        check_val("mid_reset HI", HI, 32'd0);
        check_val("mid_reset LO", LO, 32'd0);
        Op_Divu = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_val("post_reset idle stall", {31'd0, EX_ALU_Stall}, 32'd0);
        check_val("post_reset hilo_write", {31'd0, HiLo_Write}, 32'd0);
        @(posedge clock);
        #1;
        do_div("post_reset_divu_20_6", 1'b0, 1'b1, 32'd20, 32'd6, 0, 32'd3, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
